crc_sequencer: RTL and testbench

- Streaming controller that feeds a byte-wide message, bit by bit, into the team's bit-serial crcN engine.
- Accepts bytes over a valid/ready handshake, pulses crcN's initialize at message start, then drives shift and bit_index for 8 cycles per byte.
- Presents the final CRC with a valid/ready result handshake.
- Sits between the host byte interface (I/O pins or a UART front end) and crcN; crcN's configuration inputs (poly, init_value, xor_out, reflect_*, bitwidth) pass straight through and are not handled here.

---
 rtl/crc_pkg.sv | 15 +
 rtl/crc_sequencer.sv | 118 +++++++++++
 tb/tb_crc_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the CRC byte sequencer.
package crc_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int BIT_INDEX_W   = 3;

    typedef logic [2:0] crc_seq_state_t;

    localparam crc_seq_state_t IDLE      = 3'd0;
    localparam crc_seq_state_t INIT      = 3'd1;
    localparam crc_seq_state_t WAIT_BYTE = 3'd2;
    localparam crc_seq_state_t SHIFT     = 3'd3;
    localparam crc_seq_state_t DONE      = 3'd4;

endpackage

// File: rtl/crc_sequencer.sv
// Byte-to-bit sequencer for the bit-serial crcN engine: accepts message
// bytes over valid/ready, walks each byte through crcN one bit per cycle
// and hands the final CRC out over a valid/ready result port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no message in progress, waiting for start
// INIT      | one cycle, crcN loads its init value, byte count cleared
// WAIT_BYTE | in_ready high, waiting for the next message byte
// SHIFT     | eight cycles, bit_index 0..7 of the latched byte
// DONE      | result valid, held until the consumer takes it
module crc_sequencer
    import crc_pkg::*;
#(
    parameter int MAX_BITS   = 64,
    parameter int COUNT_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   crc_initialize,
    output logic                   crc_shift,
    output logic [7:0]             crc_data,
    output logic [BIT_INDEX_W-1:0] crc_bit_index,
    input  logic [MAX_BITS-1:0]    crc_value,
    output logic                   res_valid,
    output logic [MAX_BITS-1:0]    res_crc,
    input  logic                   res_ready,
    output logic [COUNT_BITS-1:0]  byte_count,
    output logic                   busy
);

    localparam logic [BIT_INDEX_W-1:0] LAST_BIT   = BIT_INDEX_W'(BITS_PER_BYTE - 1);
    localparam logic [COUNT_BITS-1:0]  COUNT_MAX  = {COUNT_BITS{1'b1}};

    crc_seq_state_t           state_q;
    crc_seq_state_t           state_d;
    logic [7:0]               data_q;
    logic [BIT_INDEX_W-1:0]   bit_idx_q;
    logic                     last_q;
    logic [COUNT_BITS-1:0]    count_q;
    logic                     accept;
    logic                     msg_begin;

    // abort overrides every other input, so it gates the datapath events too
    assign accept    = (state_q == WAIT_BYTE) && in_valid && !abort;
    assign msg_begin = (state_q == IDLE) && start && !abort;

    // next-state decode
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (start) state_d = INIT;
                INIT:      state_d = WAIT_BYTE;
                WAIT_BYTE: if (in_valid) state_d = SHIFT;
                SHIFT:     if (bit_idx_q == LAST_BIT) state_d = last_q ? DONE : WAIT_BYTE;
                DONE:      if (res_ready) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // byte latch and bit walker; the byte stays put for the whole SHIFT run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= 8'h00;
            last_q    <= 1'b0;
            bit_idx_q <= '0;
        end else if (accept) begin
            data_q    <= in_data;
            last_q    <= in_last;
            bit_idx_q <= '0;
        end else if ((state_q == SHIFT) && !abort) begin
            bit_idx_q <= bit_idx_q + 1'b1;
        end
    end

    // byte counter: cleared as the message begins, saturates, survives abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (msg_begin) begin
            count_q <= '0;
        end else if (accept && (count_q != COUNT_MAX)) begin
            count_q <= count_q + COUNT_BITS'(1);
        end
    end

    assign in_ready       = (state_q == WAIT_BYTE);
    assign crc_initialize = (state_q == INIT);
    assign crc_shift      = (state_q == SHIFT);
    assign res_valid      = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign crc_data       = data_q;
    assign crc_bit_index  = bit_idx_q;
    assign byte_count     = count_q;
    // crcN holds its register in DONE, so passing it through keeps res_crc
    // stable; gating keeps the port at zero whenever no result is offered
    assign res_crc        = res_valid ? crc_value : '0;

endmodule

// File: tb/tb_crc_sequencer.sv
// Directed bench for crc_sequencer with a behavioural bit-serial CRC engine.
module tb_crc_sequencer;

    localparam int MAX_BITS   = 64;
    localparam int COUNT_BITS = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic                  in_valid = 1'b0;
    logic [7:0]            in_data = 8'h00;
    logic                  in_last = 1'b0;
    logic                  in_ready;
    logic                  crc_initialize;
    logic                  crc_shift;
    logic [7:0]            crc_data;
    logic [2:0]            crc_bit_index;
    logic [MAX_BITS-1:0]   crc_value;
    logic                  res_valid;
    logic [MAX_BITS-1:0]   res_crc;
    logic                  res_ready = 1'b0;
    logic [COUNT_BITS-1:0] byte_count;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int init_cnt = 0;

    logic [63:0] cfg_poly;
    logic [63:0] cfg_init;
    logic [63:0] cfg_xor;
    logic        cfg_refin;
    logic        cfg_refout;
    int          cfg_w;
    logic [63:0] lfsr;
    logic [7:0]  msg_q[$];

    always #5 clk = ~clk;

    crc_sequencer #(.MAX_BITS(MAX_BITS), .COUNT_BITS(COUNT_BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .crc_initialize(crc_initialize), .crc_shift(crc_shift), .crc_data(crc_data),
        .crc_bit_index(crc_bit_index), .crc_value(crc_value),
        .res_valid(res_valid), .res_crc(res_crc), .res_ready(res_ready),
        .byte_count(byte_count), .busy(busy)
    );

    function automatic logic [63:0] wmask(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] refl(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < w; k++) r[k] = v[w-1-k];
        return r;
    endfunction

    function automatic logic [63:0] crc_step(input logic [63:0] l, input logic [7:0] d,
                                             input int idx, input logic [63:0] poly,
                                             input int w, input logic refin);
        logic b;
        logic fb;
        logic [63:0] n;
        b  = refin ? d[idx] : d[7-idx];
        fb = l[w-1] ^ b;
        n  = (l << 1) & wmask(w);
        if (fb) n = n ^ poly;
        return n;
    endfunction

    // behavioural crcN, reset by the same rst
    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= '0;
        else if (crc_initialize) lfsr <= cfg_init;
        else if (crc_shift) lfsr <= crc_step(lfsr, crc_data, int'(crc_bit_index), cfg_poly, cfg_w, cfg_refin);
    end

    assign crc_value = (cfg_refout ? refl(lfsr, cfg_w) : lfsr) ^ cfg_xor;

    always @(posedge clk) if (rst && crc_initialize) init_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_crc32();
        cfg_poly = 64'h04C1_1DB7; cfg_init = 64'hFFFF_FFFF; cfg_xor = 64'hFFFF_FFFF;
        cfg_refin = 1'b1; cfg_refout = 1'b1; cfg_w = 32;
    endtask

    task automatic cfg_crc16();
        cfg_poly = 64'h1021; cfg_init = 64'hFFFF; cfg_xor = 64'h0;
        cfg_refin = 1'b0; cfg_refout = 1'b0; cfg_w = 16;
    endtask

    task automatic cfg_crc8();
        cfg_poly = 64'h07; cfg_init = 64'h0; cfg_xor = 64'h0;
        cfg_refin = 1'b0; cfg_refout = 1'b0; cfg_w = 8;
    endtask

    task automatic load_digits();
        msg_q = {};
        for (int k = 0; k < 9; k++) msg_q.push_back(8'h31 + 8'(k));
    endtask

    function automatic int gap_for(input int i, input int max_gap);
        return (max_gap > 0) ? (i % (max_gap + 1)) : 0;
    endfunction

    // mode: 0 plain, 1 abort, 2 async reset, 3 start pulse, at (ev_byte, ev_bit)
    task automatic send_msg(input int max_gap, input int mode, input int ev_byte, input int ev_bit);
        int  last;
        int  gap;
        int  n;
        bit  bad;
        last = msg_q.size() - 1;
        start = 1'b1; tick(); start = 1'b0;
        check_eq("init_pulse", crc_initialize, 1);
        tick();
        check_eq("init_to_wait", {crc_initialize, in_ready}, 2'b01);
        check_eq("count_cleared", byte_count, 0);
        for (int i = 0; i <= last; i++) begin
            gap = gap_for(i, max_gap);
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) tick();
            end
            in_valid = 1'b1; in_data = msg_q[i]; in_last = (i == last);
            n = 0;
            while (!in_ready && n < 40) begin tick(); n++; end
            if (!in_ready) begin
                check_eq("ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            tick();
            in_valid = 1'b0;
            // keep the next byte on the bus through SHIFT when there is no gap
            if (i < last && gap_for(i + 1, max_gap) == 0) begin
                in_valid = 1'b1; in_data = msg_q[i+1]; in_last = (i + 1 == last);
            end
            n = 0; bad = 0;
            while (!in_ready && !res_valid && n < 40) begin
                if (crc_shift !== 1'b1 || crc_bit_index !== 3'(n) || crc_data !== msg_q[i]) bad = 1;
                if (i == ev_byte && n == ev_bit && mode == 1) begin
                    abort = 1'b1; tick(); abort = 1'b0; in_valid = 1'b0;
                    check_eq("abort_shift_off", crc_shift, 0);
                    check_eq("abort_idle", busy, 0);
                    check_eq("abort_no_result", res_valid, 0);
                    check_eq("abort_count_kept", byte_count, ev_byte + 1);
                    return;
                end
                if (i == ev_byte && n == ev_bit && mode == 2) begin
                    #2 rst = 1'b0;
                    #1;
                    in_valid = 1'b0;
                    check_eq("rst_ctrl_zero", {in_ready, crc_initialize, crc_shift, res_valid, busy}, 0);
                    check_eq("rst_data_zero", {crc_data, crc_bit_index, byte_count}, 0);
                    check_eq("rst_res_zero", res_crc, 0);
                    repeat (2) @(posedge clk);
                    #3 rst = 1'b1;
                    repeat (3) tick();
                    check_eq("rst_release_idle", {busy, crc_initialize}, 0);
                    return;
                end
                if (i == ev_byte && n == ev_bit && mode == 3) start = 1'b1;
                tick();
                start = 1'b0;
                n++;
            end
            check_eq("shift_sequence", bad, 0);
            check_eq("ready_low_cycles", n, 8);
            if (i == last) check_eq("res_valid_t9", res_valid, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(input logic [63:0] exp, input logic [63:0] mask, input int exp_cnt,
                              input int hold, input bit start_in_done);
        int n;
        int c0;
        bit bad;
        logic [63:0] held;
        n = 0;
        while (!res_valid && n < 40) begin tick(); n++; end
        check_eq("res_valid", res_valid, 1);
        check_eq("res_crc", res_crc & mask, exp);
        check_eq("byte_count", byte_count, exp_cnt);
        if (hold > 0) begin
            held = res_crc; bad = 0;
            repeat (hold) begin
                tick();
                if (res_valid !== 1'b1 || res_crc !== held) bad = 1;
            end
            check_eq("res_hold_stable", bad, 0);
        end
        if (start_in_done) begin
            c0 = init_cnt;
            start = 1'b1; tick(); start = 1'b0; tick();
            check_eq("done_start_res", {res_valid, res_crc & mask}, {1'b1, exp});
            check_eq("done_start_no_init", init_cnt - c0, 0);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check_eq("res_taken", {res_valid, busy}, 0);
    endtask

    initial begin
        int c0;
        cfg_crc32();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ctrl", {in_ready, crc_initialize, crc_shift, res_valid, busy}, 0);
        check_eq("reset_data", {crc_data, crc_bit_index, byte_count}, 0);
        check_eq("reset_res", res_crc, 0);
        #3 rst = 1'b1;
        repeat (2) tick();
        check_eq("idle_after_reset", busy, 0);

        // CRC-32 check value, no gaps, next byte waiting on the bus during SHIFT
        cfg_crc32(); load_digits();
        send_msg(0, 0, -1, -1);
        get_result(64'hCBF4_3926, 64'hFFFF_FFFF, 9, 0, 0);

        // CRC-16/CCITT-FALSE with 0..5 idle cycles between bytes
        cfg_crc16(); load_digits();
        send_msg(5, 0, -1, -1);
        get_result(64'h29B1, 64'hFFFF, 9, 0, 0);

        // single-byte CRC-8, result held back by the consumer
        cfg_crc8(); msg_q = {8'h31};
        send_msg(0, 0, -1, -1);
        get_result(64'h97, 64'hFF, 1, 20, 0);

        // abort at bit 4 of the third byte, then a clean CRC-32 run
        cfg_crc32(); load_digits();
        send_msg(0, 1, 2, 4);
        repeat (12) tick();
        check_eq("abort_stays_idle", {busy, res_valid}, 0);
        send_msg(2, 0, -1, -1);
        get_result(64'hCBF4_3926, 64'hFFFF_FFFF, 9, 0, 0);

        // start during SHIFT and during DONE is ignored
        c0 = init_cnt;
        send_msg(0, 3, 1, 2);
        check_eq("shift_start_one_init", init_cnt - c0, 1);
        get_result(64'hCBF4_3926, 64'hFFFF_FFFF, 9, 0, 1);

        // start together with abort in IDLE
        c0 = init_cnt;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0; tick();
        check_eq("start_abort_idle", busy, 0);
        check_eq("start_abort_no_init", init_cnt - c0, 0);

        // byte counter saturation on an 18-byte all-zero CRC-8 message
        cfg_crc8(); msg_q = {};
        for (int k = 0; k < 18; k++) msg_q.push_back(8'h00);
        send_msg(0, 0, -1, -1);
        get_result(64'h0, 64'hFF, 15, 0, 0);

        // asynchronous reset in the middle of SHIFT, then recovery
        cfg_crc32(); load_digits();
        send_msg(0, 2, 1, 5);
        cfg_crc8(); msg_q = {8'h31};
        send_msg(0, 0, -1, -1);
        get_result(64'h97, 64'hFF, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
